// File: rtl/pir_zone_scheduler.sv
// pir_zone_scheduler: three-zone PIR motion alarm controller.
// Each raw sensor line is synchronized and debounced. Its debounced rising
// edges are latched as pending events. One shared LED/buzzer alarm channel is
// granted to zones in round-robin order, and every served event is written to
// an 8-entry circular log.
//
// Handshake note: there is no valid/ready pair here. Events are level-latched
// in pending[] and consumed by the grant in IDLE. The log is a free-running
// combinational read port.
module pir_zone_scheduler #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ALARM_CYCLES    = 100,
  parameter int COOLDOWN_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] pir_sensor,
  input  logic [2:0] zone_enable,
  input  logic       stop_alarm,
  output logic       LED,
  output logic       buzzer,
  output logic [1:0] active_zone,
  output logic [2:0] pending,
  output logic       overrun,
  input  logic [2:0] log_rd_addr,
  output logic [7:0] log_rd_data,
  output logic [3:0] log_count,
  output logic [1:0] o_dbg_state
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ALW = $clog2(ALARM_CYCLES + 1);
  localparam int CDW = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ALW-1:0] ALARM_LAST = ALW'(ALARM_CYCLES - 1);
  localparam logic [CDW-1:0] COOL_LAST  = CDW'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ALARM    = 2'd1,
    S_LOG      = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_db_level;
  logic [2:0]       r_level_d;
  logic [2:0]       r_rise;
  logic [DBW-1:0]   r_db_cnt [3];

  logic [2:0]       r_pending;
  logic             r_overrun;
  logic [1:0]       r_rr_ptr;
  logic [1:0]       r_active_zone;
  logic             r_alarm_on;
  logic [ALW-1:0]   r_alarm_cnt;
  logic [CDW-1:0]   r_cool_cnt;

  logic [7:0]       r_log [8];
  logic [2:0]       r_wr_ptr;
  logic [5:0]       r_seq;
  logic [3:0]       r_log_count;

  logic [1:0]       w_grant_id;
  logic [2:0]       w_grant_mask;
  logic [2:0]       w_set;

  // Round-robin pick: first pending zone strictly after ptr, wrapping 3 -> 1.
  function automatic logic [1:0] rr_pick(input logic [2:0] p, input logic [1:0] ptr);
    logic [1:0] id;
    id = 2'd0;
    case (ptr)
      2'd1: begin
        if (p[1])      id = 2'd2;
        else if (p[2]) id = 2'd3;
        else if (p[0]) id = 2'd1;
      end
      2'd2: begin
        if (p[2])      id = 2'd3;
        else if (p[0]) id = 2'd1;
        else if (p[1]) id = 2'd2;
      end
      default: begin
        if (p[0])      id = 2'd1;
        else if (p[1]) id = 2'd2;
        else if (p[2]) id = 2'd3;
      end
    endcase
    return id;
  endfunction

  // Synchronize, debounce and detect debounced rising edges for each zone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_db_level <= '0;
      r_level_d  <= '0;
      r_rise     <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1   <= pir_sensor;
      r_sync2   <= r_sync1;
      r_level_d <= r_db_level;
      r_rise    <= r_db_level & ~r_level_d;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_level[i] <= r_sync2[i];
          r_db_cnt[i]   <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_set = r_rise & zone_enable;

  // Next-state and grant selection; a grant only happens out of IDLE.
  always_comb begin
    w_next_state = r_state;
    w_grant_id   = 2'd0;
    w_grant_mask = 3'b000;
    case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_grant_id   = rr_pick(r_pending, r_rr_ptr);
          w_next_state = S_ALARM;
        end
      end
      S_ALARM: begin
        if (stop_alarm || (r_alarm_cnt == ALARM_LAST)) w_next_state = S_LOG;
      end
      S_LOG: begin
        w_next_state = S_COOLDOWN;
      end
      default: begin
        if (r_cool_cnt == COOL_LAST) w_next_state = S_IDLE;
      end
    endcase
    case (w_grant_id)
      2'd1:    w_grant_mask = 3'b001;
      2'd2:    w_grant_mask = 3'b010;
      2'd3:    w_grant_mask = 3'b100;
      default: w_grant_mask = 3'b000;
    endcase
  end

  // State register plus alarm/cooldown timers, which restart from 0 on each entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_alarm_cnt <= '0;
      r_cool_cnt  <= '0;
    end else begin
      r_state     <= w_next_state;
      r_alarm_cnt <= (r_state == S_ALARM)    ? r_alarm_cnt + 1'b1 : '0;
      r_cool_cnt  <= (r_state == S_COOLDOWN) ? r_cool_cnt + 1'b1  : '0;
    end
  end

  // Alarm outputs, served zone and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alarm_on    <= 1'b0;
      r_active_zone <= 2'd0;
      r_rr_ptr      <= 2'd3;
    end else begin
      r_alarm_on <= (w_next_state == S_ALARM);
      if (w_grant_id != 2'd0) begin
        r_active_zone <= w_grant_id;
        r_rr_ptr      <= w_grant_id;
      end else if (r_state == S_LOG) begin
        r_active_zone <= 2'd0;
      end
    end
  end

  // Event latch: a new rise beats a same-cycle grant clear; a rise on an
  // already pending zone is coalesced and flagged as overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 3'b000;
      r_overrun <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_grant_mask) | w_set;
      if (|(w_set & r_pending & ~w_grant_mask)) r_overrun <= 1'b1;
    end
  end

  // Circular event log, written once per served event during LOG.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_log[i] <= '0;
      r_wr_ptr    <= '0;
      r_seq       <= '0;
      r_log_count <= '0;
    end else if (r_state == S_LOG) begin
      r_log[r_wr_ptr] <= {r_active_zone, r_seq};
      r_wr_ptr        <= r_wr_ptr + 3'd1;
      r_seq           <= r_seq + 6'd1;
      if (r_log_count != 4'd8) r_log_count <= r_log_count + 4'd1;
    end
  end

  assign LED         = r_alarm_on;
  assign buzzer      = r_alarm_on;
  assign active_zone = r_active_zone;
  assign pending     = r_pending;
  assign overrun     = r_overrun;
  assign log_rd_data = r_log[log_rd_addr];
  assign log_count   = r_log_count;
  assign o_dbg_state = r_state;

endmodule

// File: doc/pir_zone_scheduler.md
Name: pir_zone_scheduler

Overview:
- Multi-zone motion alarm controller. Takes three raw PIR sensor lines, then synchronizes and debounces each one.
- Latches motion events per zone and grants one shared LED/buzzer alarm channel to zones in round-robin order.
- Records every served event in an 8-entry circular event log, which firmware and the display path read.
- Sits between the PIR sensor pins and the alarm/display outputs, replacing the single-zone alarm FSM.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized samples that must differ from the debounced level before it flips.
- ALARM_CYCLES, 100: maximum ALARM state duration in cycles.
- COOLDOWN_CYCLES, 8: idle gap after each served event before the next grant.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pir_sensor  in  3  raw asynchronous sensor lines; bit i = zone i+1.
- zone_enable  in  3  per-zone arm mask; 0 = new events from that zone ignored.
- stop_alarm  in  1  synchronous, level; aborts the current alarm.
- LED  out  1  alarm indicator.
- buzzer  out  1  alarm sounder.
- active_zone  out  2  zone being served (1..3), 0 = none.
- pending  out  3  latched, unserved events per zone.
- overrun  out  1  sticky; an event was dropped.
- log_rd_addr  in  3  log read index.
- log_rd_data  out  8  combinational read of log[log_rd_addr]: [7:6] zone id, [5:0] sequence number.
- log_count  out  4  valid log entries, saturates at 8.

Behaviour:
- Reset (async) clears:
  - LED=0, buzzer=0, active_zone=0, pending=0, overrun=0, log_count=0.
  - All log entries=0, write pointer=0, sequence=0, FSM=IDLE.
  - RR pointer = zone 3, so zone 1 has first priority.
  - All sync/debounce state = 0.
  - Reset mid-alarm drops LED/buzzer immediately; no log write occurs.
- Input conditioning per zone:
  - 2-flop synchronizer, then debounce counter.
  - A sample != debounced level increments the counter; a matching sample clears it.
  - Counter reaching DEBOUNCE_CYCLES flips the debounced level and clears the counter.
  - A clean rise sampled at edge n sets pending[i] at edge n+DEBOUNCE_CYCLES+3.
  - Glitches shorter than DEBOUNCE_CYCLES samples produce no event.
- Event latch:
  - A debounced rising edge with zone_enable[i]=1 sets pending[i].
  - If pending[i] is already 1, set overrun=1 and leave pending[i]=1 (event coalesced).
  - Falling edges are ignored.
  - Deasserting zone_enable does not clear existing pending bits.
  - If a set and a grant-clear hit the same bit in the same cycle, the set wins and overrun is not flagged.
- FSM states:
  - IDLE:
    - If pending != 0, grant the first set bit searching upward from RR pointer+1 (wrap 3->1).
    - On grant: clear that pending bit, active_zone = id, RR pointer = id, go to ALARM.
    - Otherwise stay in IDLE.
  - ALARM:
    - LED=1 and buzzer=1 in every ALARM cycle, registered; they rise on the edge that enters ALARM.
    - Cycle counter starts at 0.
    - Exit to LOG when counter == ALARM_CYCLES-1, or when stop_alarm=1 is sampled, whichever comes first.
    - stop_alarm high on the entry cycle gives a 1-cycle alarm.
  - LOG (1 cycle):
    - LED=0, buzzer=0.
    - Write {active_zone, sequence} to log[wr_ptr]; wr_ptr wraps 7->0.
    - sequence wraps 63->0; log_count = min(log_count+1, 8).
    - Once the log is full, the oldest entry is overwritten.
    - Go to COOLDOWN.
  - COOLDOWN:
    - active_zone=0; wait COOLDOWN_CYCLES cycles, then go to IDLE.
    - pending continues to accumulate.
- stop_alarm outside ALARM has no effect.
- A multi-zone simultaneous rise sets all corresponding pending bits in one cycle; they are served in RR order.
- Unwritten log slots read 0.

Test Plan:
- Reset, then pir_sensor=001 held high -> pending=001 after 7 edges (DEBOUNCE_CYCLES=4). Next cycle: active_zone=1, LED=buzzer=1 for exactly 100 cycles. Then log_rd_data[addr0]=0x40, log_count=1.
- 3-cycle pulse on zone 2 -> pending stays 000, no alarm, log_count=0.
- All three sensors rise together -> served in order zone 1,2,3, each separated by LOG+8 cooldown cycles. Log entries 0x40, 0x81, 0xC2.
- During zone 1 ALARM, stop_alarm high on alarm cycle 10 -> LED/buzzer low after 10 alarm cycles. Entry logged with zone 1; zone 2 event pending during the alarm is granted after cooldown.
- Zone 3 toggles twice (debounced) while zone 1 alarm runs -> pending=100, overrun=1 (sticky until rst). zone_enable=011 with zone 3 rising -> no pending, no overrun.
- 10 served events -> log_count=8, wr_ptr=2, log[0]=seq 8, log[1]=seq 9. Assert rst mid-ALARM -> LED=0 asynchronously, all outputs at reset values.
